// File: rtl/cv32e40x_fencei_sequencer_pkg.sv
// Shared types for the fence.i flush sequencer: state encoding and the
// per-state control decode that the sequencer registers onto its outputs.
package cv32e40x_fencei_sequencer_pkg;

    typedef enum logic [1:0] {
        FENCEI_IDLE    = 2'd0,
        FENCEI_DRAIN   = 2'd1,
        FENCEI_FLUSH   = 2'd2,
        FENCEI_RESTART = 2'd3
    } fencei_state_e;

    typedef struct packed {
        logic halt_if;
        logic halt_wb;
        logic flush_req;
        logic restart;   // drives pc_set, kill_pipe and retire together
        logic busy;
    } fencei_ctrl_t;

    function automatic fencei_ctrl_t fencei_decode(input fencei_state_e s);
        fencei_ctrl_t c;
        c = '0;
        case (s)
            FENCEI_DRAIN: begin
                c.halt_if = 1'b1;
                c.halt_wb = 1'b1;
                c.busy    = 1'b1;
            end
            FENCEI_FLUSH: begin
                c.halt_if   = 1'b1;
                c.halt_wb   = 1'b1;
                c.flush_req = 1'b1;
                c.busy      = 1'b1;
            end
            FENCEI_RESTART: begin
                c.restart = 1'b1;
                c.busy    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cv32e40x_fencei_sequencer.sv
// fence.i flush sequencer: holds the fence.i in WB, drains the LSU, runs the
// flush req/ack handshake, then retires and restarts fetch at PC+4.
module cv32e40x_fencei_sequencer
    import cv32e40x_fencei_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fencei_wb_i,
    input  logic             lsu_busy_i,
    input  logic             lsu_write_buffer_empty_i,
    input  logic             fencei_flush_ack_i,
    output logic             halt_if_o,
    output logic             halt_wb_o,
    output logic             fencei_flush_req_o,
    output logic             pc_set_o,
    output logic             kill_pipe_o,
    output logic             retire_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fencei_state_e    state_q, state_d;
    fencei_ctrl_t     ctrl_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FENCEI_IDLE:    if (fencei_wb_i) state_d = FENCEI_DRAIN;
            FENCEI_DRAIN:   if (!lsu_busy_i && lsu_write_buffer_empty_i) state_d = FENCEI_FLUSH;
            FENCEI_FLUSH:   if (fencei_flush_ack_i) state_d = FENCEI_RESTART;
            FENCEI_RESTART: state_d = FENCEI_IDLE;
            default:        state_d = FENCEI_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every output
    // is a flop aligned with state_q and has no path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FENCEI_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= fencei_decode(state_d);
            if (state_q == FENCEI_IDLE && fencei_wb_i) begin
                cnt_q <= '0;
            end else if ((state_q == FENCEI_DRAIN || state_q == FENCEI_FLUSH) && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign halt_if_o          = ctrl_q.halt_if;
    assign halt_wb_o          = ctrl_q.halt_wb;
    assign fencei_flush_req_o = ctrl_q.flush_req;
    assign pc_set_o           = ctrl_q.restart;
    assign kill_pipe_o        = ctrl_q.restart;
    assign retire_o           = ctrl_q.restart;
    assign busy_o             = ctrl_q.busy;
    assign stall_cnt_o        = cnt_q;

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        fencei_flush_req_o && !fencei_flush_ack_i |=> fencei_flush_req_o);

    a_restart_eq: assert property (@(posedge clk)
        (pc_set_o == retire_o) && (kill_pipe_o == retire_o));

    a_single_retire: assert property (@(posedge clk) disable iff (rst)
        retire_o |=> !retire_o);

    a_ack_in_flush: assert property (@(posedge clk) disable iff (rst)
        fencei_flush_ack_i |-> state_q == FENCEI_FLUSH);

endmodule
